// File: rtl/regfile_write_arb.sv
// Two-client write arbiter for a single register-file write port.
// Round-robin in IDLE, bounded burst ownership via per-client lock, registered write drive.
module regfile_write_arb #(
  parameter int MAXLOCK = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        c0_valid,
  input  logic        c1_valid,
  input  logic        c0_lock,
  input  logic        c1_lock,
  input  logic [4:0]  c0_addr,
  input  logic [4:0]  c1_addr,
  input  logic [31:0] c0_data,
  input  logic [31:0] c1_data,
  output logic        c0_ready,
  output logic        c1_ready,
  output logic        we3,
  output logic [4:0]  wa3,
  output logic [31:0] wd3,
  output logic [15:0] c0_cnt,
  output logic [15:0] c1_cnt,
  output logic [1:0]  owner
);

  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] LOCK0 = 2'b01;
  localparam logic [1:0] LOCK1 = 2'b10;
  localparam logic [3:0] MAXLOCK_C = 4'(MAXLOCK);
  // A one-write burst is indistinguishable from an unlocked write, so never enter LOCKn.
  localparam bit LOCK_EN = (MAXLOCK > 1);

  logic [1:0]  state_q, state_d;
  logic        rr_q, rr_d;
  logic [3:0]  burst_q, burst_d;
  logic        we3_q, we3_d;
  logic [4:0]  wa3_q, wa3_d;
  logic [31:0] wd3_q, wd3_d;
  logic [15:0] c0_cnt_q, c0_cnt_d;
  logic [15:0] c1_cnt_q, c1_cnt_d;

  logic        gnt0, gnt1, xfer;
  logic [4:0]  sel_addr;
  logic [31:0] sel_data;

  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!reset) begin
      case (state_q)
        IDLE: begin
          gnt0 = c0_valid && (!c1_valid || !rr_q);
          gnt1 = c1_valid && (!c0_valid || rr_q);
        end
        LOCK0:   gnt0 = c0_valid;
        LOCK1:   gnt1 = c1_valid;
        default: ;
      endcase
    end
  end

  assign xfer     = gnt0 || gnt1;
  assign sel_addr = gnt1 ? c1_addr : c0_addr;
  assign sel_data = gnt1 ? c1_data : c0_data;

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    burst_d = burst_q;
    case (state_q)
      IDLE: begin
        if (gnt0) begin
          rr_d = 1'b1;
          if (c0_lock && LOCK_EN) begin
            state_d = LOCK0;
            burst_d = 4'd1;
          end
        end else if (gnt1) begin
          rr_d = 1'b0;
          if (c1_lock && LOCK_EN) begin
            state_d = LOCK1;
            burst_d = 4'd1;
          end
        end
      end
      // Owner may still complete one last write in the cycle it drops lock.
      LOCK0: begin
        if (!c0_valid || !c0_lock || (burst_q + 4'd1 >= MAXLOCK_C)) begin
          state_d = IDLE;
          rr_d    = 1'b1;
          burst_d = 4'd0;
        end else begin
          burst_d = burst_q + 4'd1;
        end
      end
      LOCK1: begin
        if (!c1_valid || !c1_lock || (burst_q + 4'd1 >= MAXLOCK_C)) begin
          state_d = IDLE;
          rr_d    = 1'b0;
          burst_d = 4'd0;
        end else begin
          burst_d = burst_q + 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        burst_d = 4'd0;
      end
    endcase
  end

  // Writes to r0 are accepted but suppressed; address/data hold their last real write.
  always_comb begin
    we3_d    = xfer && (sel_addr != 5'd0);
    wa3_d    = we3_d ? sel_addr : wa3_q;
    wd3_d    = we3_d ? sel_data : wd3_q;
    c0_cnt_d = gnt0 ? sat_inc(c0_cnt_q) : c0_cnt_q;
    c1_cnt_d = gnt1 ? sat_inc(c1_cnt_q) : c1_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      rr_q     <= 1'b0;
      burst_q  <= 4'd0;
      we3_q    <= 1'b0;
      wa3_q    <= 5'd0;
      wd3_q    <= 32'd0;
      c0_cnt_q <= 16'd0;
      c1_cnt_q <= 16'd0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      burst_q  <= burst_d;
      we3_q    <= we3_d;
      wa3_q    <= wa3_d;
      wd3_q    <= wd3_d;
      c0_cnt_q <= c0_cnt_d;
      c1_cnt_q <= c1_cnt_d;
    end
  end

  assign c0_ready = gnt0;
  assign c1_ready = gnt1;
  assign we3      = we3_q;
  assign wa3      = wa3_q;
  assign wd3      = wd3_q;
  assign c0_cnt   = c0_cnt_q;
  assign c1_cnt   = c1_cnt_q;
  assign owner    = state_q;

endmodule
